// File: rtl/inst_queue.sv
// inst_queue: circular instruction buffer between fetch and decode.
// Pre-decodes branches and jumps on enqueue and presents up to ISSUE_W
// in-order instructions per cycle.
// Optional feature macro: INST_QUEUE_DS_PAIR_EN keeps each branch in the
// same issue group as its delay slot and drives out_ds.
module inst_queue #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_count,
  input  logic [32*FETCH_W-1:0]  in_inst,
  input  logic [32*FETCH_W-1:0]  in_pc,
  input  logic [FETCH_W-1:0]     in_adel,
  output logic [ISSUE_W-1:0]     out_valid,
  output logic [32*ISSUE_W-1:0]  out_inst,
  output logic [32*ISSUE_W-1:0]  out_pc,
  output logic [ISSUE_W-1:0]     out_adel,
  output logic [ISSUE_W-1:0]     out_br,
  output logic [ISSUE_W-1:0]     out_ds,
  input  logic [1:0]             out_take
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  // Presentation window is always evaluated two slots wide; slot 1 is
  // masked off when ISSUE_W is 1.
  localparam int unsigned SLOTS = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
    logic        br;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
`ifdef INST_QUEUE_DS_PAIR_EN
  logic            ds_pending_q, ds_pending_d;
`endif

  logic            enq;
  logic [CW-1:0]   enq_n;
  logic [CW-1:0]   avail;
  logic [CW-1:0]   take;
  logic [AW-1:0]   widx;
  entry_t          slot_e [SLOTS];
  logic [SLOTS-1:0] slot_cand;
  logic [SLOTS-1:0] slot_valid;
  logic [SLOTS-1:0] slot_ds;

  // Branch/jump pre-decode: J/JAL/BEQ/BNE/BLEZ/BGTZ, REGIMM branches, JR/JALR.
  function automatic logic is_branch(input logic [31:0] inst);
    logic [5:0] opcode;
    logic [4:0] rt;
    logic [5:0] func;
    opcode    = inst[31:26];
    rt        = inst[20:16];
    func      = inst[5:0];
    is_branch = 1'b0;
    case (opcode)
      6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7:
        is_branch = 1'b1;
      6'd1:
        is_branch = (rt == 5'd0) || (rt == 5'd1) || (rt == 5'd16) || (rt == 5'd17);
      6'd0:
        is_branch = (func == 6'd8) || (func == 6'd9);
      default:
        is_branch = 1'b0;
    endcase
  endfunction

  // Accept only when a full FETCH_W packet fits, based on current occupancy.
  always_comb begin
    in_ready = (count_q <= CW'(DEPTH - FETCH_W));
    enq      = in_valid && in_ready && !flush;
    enq_n    = enq ? CW'(in_count) : '0;
  end

  // Read the head window and decide which slots may issue this cycle.
  always_comb begin
    slot_valid = '0;
    slot_ds    = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      slot_e[k]    = mem_q[AW'(head_q + AW'(k))];
      slot_cand[k] = (count_q > CW'(k)) && (k < ISSUE_W);
    end
`ifdef INST_QUEUE_DS_PAIR_EN
    // A branch waits until its delay slot is queued; a branch in slot 1
    // waits for the next group so it can travel with its delay slot.
    slot_valid[0] = slot_cand[0] && (!slot_e[0].br || (count_q > CW'(1)));
    slot_valid[1] = slot_valid[0] && slot_cand[1] && (slot_e[0].br || !slot_e[1].br);
    slot_ds[0]    = slot_valid[0] && ds_pending_q;
    slot_ds[1]    = slot_valid[1] && slot_e[0].br;
`else
    slot_valid = slot_cand;
`endif
  end

  // Drive the decode-facing outputs from the issue window.
  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    out_adel  = '0;
    out_br    = '0;
    out_ds    = '0;
    for (int unsigned k = 0; k < ISSUE_W; k++) begin
      out_valid[k]       = slot_valid[k];
      out_inst[32*k +: 32] = slot_e[k].inst;
      out_pc[32*k +: 32]   = slot_e[k].pc;
      out_adel[k]        = slot_valid[k] && slot_e[k].adel;
      out_br[k]          = slot_valid[k] && slot_e[k].br;
      out_ds[k]          = slot_ds[k];
    end
  end

  // Clamp the consumer's take to the number of slots actually presented.
  always_comb begin
    avail = CW'(slot_valid[0]) + CW'(slot_valid[1]);
    take  = (CW'(out_take) < avail) ? CW'(out_take) : avail;
  end

  // Next-state: flush clears pointers; otherwise write packet and advance.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    widx    = '0;
`ifdef INST_QUEUE_DS_PAIR_EN
    ds_pending_d = ds_pending_q;
`endif
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
`ifdef INST_QUEUE_DS_PAIR_EN
      ds_pending_d = 1'b0;
`endif
    end else begin
      for (int unsigned i = 0; i < FETCH_W; i++) begin
        if (enq && (CW'(i) < enq_n)) begin
          widx        = AW'(tail_q + AW'(i));
          mem_d[widx] = '{inst: in_inst[32*i +: 32],
                          pc:   in_pc[32*i +: 32],
                          adel: in_adel[i],
                          br:   is_branch(in_inst[32*i +: 32])};
        end
      end
      tail_d  = AW'(tail_q + AW'(enq_n));
      head_d  = AW'(head_q + AW'(take));
      count_d = CW'(count_q + enq_n - take);
`ifdef INST_QUEUE_DS_PAIR_EN
      // A lone branch taken as the last slot leaves its delay slot at head.
      if (take == CW'(1)) begin
        ds_pending_d = slot_e[0].br && !slot_ds[0];
      end else if (take != '0) begin
        ds_pending_d = 1'b0;
      end
`endif
    end
  end

  // Pointer, occupancy and pairing state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
`ifdef INST_QUEUE_DS_PAIR_EN
      ds_pending_q <= 1'b0;
`endif
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
`ifdef INST_QUEUE_DS_PAIR_EN
      ds_pending_q <= ds_pending_d;
`endif
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed testbench for inst_queue: a 16-deep dual-issue instance and a
// 4-deep single-issue instance, with expectations for both pairing modes.
module tb_inst_queue;

`ifdef INST_QUEUE_DS_PAIR_EN
  localparam bit PAIR = 1'b1;
`else
  localparam bit PAIR = 1'b0;
`endif

  localparam logic [31:0] I_ADDU    = 32'h01094021;
  localparam logic [31:0] I_ADDIU   = 32'h25080001;
  localparam logic [31:0] I_BEQ     = 32'h11090003;
  localparam logic [31:0] I_NOP     = 32'h00000000;
  localparam logic [31:0] I_JR      = 32'h03E00008;
  localparam logic [31:0] I_SYSCALL = 32'h0000000C;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // DUT a: DEPTH=16, FETCH_W=2, ISSUE_W=2
  logic        a_flush, a_in_valid, a_in_ready;
  logic [1:0]  a_in_count, a_in_adel, a_out_take;
  logic [63:0] a_in_inst, a_in_pc, a_out_inst, a_out_pc;
  logic [1:0]  a_out_valid, a_out_adel, a_out_br, a_out_ds;

  // DUT b: DEPTH=4, FETCH_W=2, ISSUE_W=1
  logic        b_flush, b_in_valid, b_in_ready;
  logic [1:0]  b_in_count, b_in_adel, b_out_take;
  logic [63:0] b_in_inst, b_in_pc;
  logic [31:0] b_out_inst, b_out_pc;
  logic        b_out_valid, b_out_adel, b_out_br, b_out_ds;

  inst_queue #(.DEPTH(16), .FETCH_W(2), .ISSUE_W(2)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_count(a_in_count), .in_inst(a_in_inst), .in_pc(a_in_pc), .in_adel(a_in_adel),
    .out_valid(a_out_valid), .out_inst(a_out_inst), .out_pc(a_out_pc), .out_adel(a_out_adel),
    .out_br(a_out_br), .out_ds(a_out_ds), .out_take(a_out_take)
  );

  inst_queue #(.DEPTH(4), .FETCH_W(2), .ISSUE_W(1)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_count(b_in_count), .in_inst(b_in_inst), .in_pc(b_in_pc), .in_adel(b_in_adel),
    .out_valid(b_out_valid), .out_inst(b_out_inst), .out_pc(b_out_pc), .out_adel(b_out_adel),
    .out_br(b_out_br), .out_ds(b_out_ds), .out_take(b_out_take)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_pkt(input logic v, input logic [1:0] n, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1, input logic [1:0] adel);
    a_in_valid = v; a_in_count = n; a_in_inst = {i1, i0}; a_in_pc = {p1, p0}; a_in_adel = adel;
  endtask

  task automatic b_pkt(input logic v, input logic [1:0] n, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1);
    b_in_valid = v; b_in_count = n; b_in_inst = {i1, i0}; b_in_pc = {p1, p0}; b_in_adel = 2'b00;
  endtask

  task automatic idle_all();
    a_flush = 1'b0; a_out_take = 2'd0; a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    b_flush = 1'b0; b_out_take = 2'd0; b_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_out_valid !== 2'b00) begin errors++; $display("FAIL rst_a_valid got %b want 00", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready got %b want 1", a_in_ready); end
    checks++; if ({a_out_br, a_out_ds} !== 4'b0000) begin errors++; $display("FAIL rst_a_br_ds got %b want 0000", {a_out_br, a_out_ds}); end
    checks++; if ({b_out_valid, b_in_ready, b_out_br, b_out_ds} !== 4'b0100) begin errors++; $display("FAIL rst_b got %b want 0100", {b_out_valid, b_in_ready, b_out_br, b_out_ds}); end
  endtask

  task automatic test_basic();
    do_reset();
    a_pkt(1'b1, 2'd2, I_ADDU, 32'hBFC00000, I_ADDIU, 32'hBFC00004, 2'b00);
    tick();
    a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    checks++; if (a_out_valid !== 2'b11) begin errors++; $display("FAIL basic_valid got %b want 11", a_out_valid); end
    checks++; if (a_out_pc !== {32'hBFC00004, 32'hBFC00000}) begin errors++; $display("FAIL basic_pc got %h want bfc00004bfc00000", a_out_pc); end
    checks++; if (a_out_inst !== {I_ADDIU, I_ADDU}) begin errors++; $display("FAIL basic_inst got %h", a_out_inst); end
    checks++; if (a_out_br !== 2'b00) begin errors++; $display("FAIL basic_br got %b want 00", a_out_br); end
    a_out_take = 2'd2;
    tick();
    a_out_take = 2'd0;
    checks++; if (a_out_valid !== 2'b00) begin errors++; $display("FAIL basic_empty got %b want 00", a_out_valid); end
  endtask

  task automatic test_predecode();
    logic [31:0] i0_t [7];
    logic [31:0] i1_t [7];
    logic [1:0]  br_t [7];
    i0_t[0] = I_BEQ;        i1_t[0] = I_NOP;        br_t[0] = 2'b01;
    i0_t[1] = 32'h04000002; i1_t[1] = 32'h20000000; br_t[1] = 2'b01;
    i0_t[2] = 32'h04020002; i1_t[2] = 32'h20000000; br_t[2] = 2'b00;
    i0_t[3] = 32'h0040F809; i1_t[3] = I_SYSCALL;    br_t[3] = 2'b01;
    i0_t[4] = 32'h08000010; i1_t[4] = 32'h0000000A; br_t[4] = 2'b01;
    i0_t[5] = 32'h04110001; i1_t[5] = 32'h04100001; br_t[5] = 2'b11;
    i0_t[6] = 32'h1C000001; i1_t[6] = 32'hFC000000; br_t[6] = 2'b01;
    do_reset();
    for (int t = 0; t < 7; t++) begin
      a_pkt(1'b1, 2'd2, i0_t[t], 32'h1000 + 32'(8*t), i1_t[t], 32'h1004 + 32'(8*t), 2'b00);
      tick();
      a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
      checks++; if (a_out_br !== br_t[t] || a_out_valid !== 2'b11) begin
        errors++; $display("FAIL predecode_%0d got br=%b valid=%b want br=%b valid=11", t, a_out_br, a_out_valid, br_t[t]);
      end
      a_out_take = 2'd2;
      tick();
      a_out_take = 2'd0;
    end
  endtask

  task automatic test_pairing();
    do_reset();
    // Non-branch then branch in one packet.
    a_pkt(1'b1, 2'd2, I_ADDU, 32'h200, I_BEQ, 32'h204, 2'b00);
    tick();
    a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    checks++; if (a_out_valid !== (PAIR ? 2'b01 : 2'b11)) begin errors++; $display("FAIL split_valid got %b", a_out_valid); end
    checks++; if (a_out_br !== (PAIR ? 2'b00 : 2'b10)) begin errors++; $display("FAIL split_br got %b", a_out_br); end
    a_out_take = 2'd2;
    tick();
    a_out_take = 2'd0;
    checks++; if (a_out_valid !== 2'b00) begin errors++; $display("FAIL held_valid got %b want 00", a_out_valid); end
    a_pkt(1'b1, 2'd1, I_NOP, 32'h208, 32'h0, 32'h0, 2'b00);
    tick();
    a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    checks++; if (a_out_valid !== (PAIR ? 2'b11 : 2'b01)) begin errors++; $display("FAIL rejoin_valid got %b", a_out_valid); end
    checks++; if (a_out_pc[31:0] !== (PAIR ? 32'h204 : 32'h208)) begin errors++; $display("FAIL rejoin_pc got %h", a_out_pc[31:0]); end
    checks++; if ({a_out_br, a_out_ds} !== (PAIR ? 4'b0110 : 4'b0000)) begin errors++; $display("FAIL rejoin_br_ds got %b", {a_out_br, a_out_ds}); end
    a_out_take = 2'd2;
    tick();
    a_out_take = 2'd0;
    // Branch enqueued alone, then its delay slot.
    a_pkt(1'b1, 2'd1, I_BEQ, 32'h300, 32'h0, 32'h0, 2'b00);
    tick();
    a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    checks++; if (a_out_valid !== (PAIR ? 2'b00 : 2'b01)) begin errors++; $display("FAIL beq_alone_valid got %b", a_out_valid); end
    a_pkt(1'b1, 2'd1, I_NOP, 32'h304, 32'h0, 32'h0, 2'b00);
    tick();
    a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    checks++; if (a_out_valid !== 2'b11) begin errors++; $display("FAIL beq_pair_valid got %b want 11", a_out_valid); end
    checks++; if ({a_out_br, a_out_ds} !== (PAIR ? 4'b0110 : 4'b0100)) begin errors++; $display("FAIL beq_pair_br_ds got %b", {a_out_br, a_out_ds}); end
    a_out_take = 2'd2;
    tick();
    a_out_take = 2'd0;
    checks++; if (a_out_valid !== 2'b00) begin errors++; $display("FAIL beq_pair_empty got %b want 00", a_out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    a_pkt(1'b1, 2'd2, I_ADDU, 32'h400, I_ADDIU, 32'h404, 2'b00);
    tick();
    a_pkt(1'b1, 2'd1, I_ADDU, 32'h408, 32'h0, 32'h0, 2'b00);
    tick();
    a_pkt(1'b1, 2'd2, I_ADDU, 32'h500, I_ADDIU, 32'h504, 2'b00);
    a_flush = 1'b1; a_out_take = 2'd2;
    tick();
    a_flush = 1'b0; a_out_take = 2'd0;
    a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    checks++; if (a_out_valid !== 2'b00 || a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_state got valid=%b ready=%b want 00/1", a_out_valid, a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 2'b00) begin errors++; $display("FAIL flush_dropped got %b want 00", a_out_valid); end
    a_pkt(1'b1, 2'd1, I_ADDU, 32'h600, 32'h0, 32'h0, 2'b00);
    tick();
    a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    checks++; if (a_out_valid !== 2'b01 || a_out_pc[31:0] !== 32'h600) begin errors++; $display("FAIL flush_restart got valid=%b pc=%h want 01/600", a_out_valid, a_out_pc[31:0]); end
  endtask

  task automatic test_adel();
    do_reset();
    a_pkt(1'b1, 2'd1, I_SYSCALL, 32'h700, 32'h0, 32'h0, 2'b01);
    tick();
    a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    checks++; if ({a_out_valid, a_out_adel, a_out_br} !== 6'b010100) begin errors++; $display("FAIL adel_flags got %b want 010100", {a_out_valid, a_out_adel, a_out_br}); end
    checks++; if (a_out_inst[31:0] !== I_SYSCALL) begin errors++; $display("FAIL adel_inst got %h want 0000000c", a_out_inst[31:0]); end
    // Over-take is clamped to the single presented slot.
    a_out_take = 2'd2;
    tick();
    a_out_take = 2'd0;
    a_pkt(1'b1, 2'd2, I_ADDU, 32'h710, I_ADDIU, 32'h714, 2'b00);
    tick();
    a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    checks++; if (a_out_valid !== 2'b11 || a_out_pc !== {32'h714, 32'h710}) begin errors++; $display("FAIL clamp_take got valid=%b pc=%h", a_out_valid, a_out_pc); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h18; exp_pc[1] = 32'h1C; exp_pc[2] = 32'h20; exp_pc[3] = 32'h24;
    do_reset();
    b_pkt(1'b1, 2'd2, 32'h24000001, 32'h10, 32'h24000002, 32'h14);
    tick();
    checks++; if (b_in_ready !== 1'b1 || b_out_pc !== 32'h10) begin errors++; $display("FAIL full_p0 got ready=%b pc=%h want 1/10", b_in_ready, b_out_pc); end
    b_pkt(1'b1, 2'd2, 32'h24000003, 32'h18, 32'h24000004, 32'h1C);
    tick();
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", b_in_ready); end
    b_pkt(1'b1, 2'd2, 32'h24000009, 32'h80, 32'h2400000A, 32'h84);
    tick();
    b_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    checks++; if (b_in_ready !== 1'b0 || b_out_pc !== 32'h10) begin errors++; $display("FAIL full_reject got ready=%b pc=%h want 0/10", b_in_ready, b_out_pc); end
    b_out_take = 2'd1;
    tick();
    checks++; if (b_in_ready !== 1'b0 || b_out_pc !== 32'h14) begin errors++; $display("FAIL drain1 got ready=%b pc=%h want 0/14", b_in_ready, b_out_pc); end
    tick();
    b_out_take = 2'd0;
    checks++; if (b_in_ready !== 1'b1 || b_out_pc !== 32'h18) begin errors++; $display("FAIL drain2 got ready=%b pc=%h want 1/18", b_in_ready, b_out_pc); end
    b_pkt(1'b1, 2'd2, 32'h24000005, 32'h20, 32'h24000006, 32'h24);
    tick();
    b_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (b_out_valid !== 1'b1 || b_out_pc !== exp_pc[k]) begin errors++; $display("FAIL wrap_%0d got valid=%b pc=%h want 1/%h", k, b_out_valid, b_out_pc, exp_pc[k]); end
      if (k == 2) begin
        checks++; if (b_out_inst !== 32'h24000005) begin errors++; $display("FAIL wrap_inst got %h want 24000005", b_out_inst); end
      end
      b_out_take = 2'd1;
      tick();
      b_out_take = 2'd0;
    end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b want 0", b_out_valid); end
  endtask

  task automatic test_single_issue_ds();
    do_reset();
    b_pkt(1'b1, 2'd1, I_JR, 32'h40, 32'h0, 32'h0);
    tick();
    b_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    checks++; if (b_out_valid !== (PAIR ? 1'b0 : 1'b1)) begin errors++; $display("FAIL jr_alone_valid got %b", b_out_valid); end
    b_pkt(1'b1, 2'd1, I_NOP, 32'h44, 32'h0, 32'h0);
    tick();
    b_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    checks++; if ({b_out_valid, b_out_br, b_out_ds} !== 3'b110 || b_out_pc !== 32'h40) begin errors++; $display("FAIL jr_cycle_a got vbd=%b pc=%h want 110/40", {b_out_valid, b_out_br, b_out_ds}, b_out_pc); end
    b_out_take = 2'd1;
    tick();
    checks++; if ({b_out_valid, b_out_br, b_out_ds} !== {2'b10, PAIR} || b_out_pc !== 32'h44) begin errors++; $display("FAIL jr_cycle_b got vbd=%b pc=%h want 10%b/44", {b_out_valid, b_out_br, b_out_ds}, b_out_pc, PAIR); end
    tick();
    b_out_take = 2'd0;
    checks++; if ({b_out_valid, b_out_ds} !== 2'b00) begin errors++; $display("FAIL jr_after got vd=%b want 00", {b_out_valid, b_out_ds}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_pkt(1'b1, 2'd2, I_ADDU, 32'h800, I_ADDIU, 32'h804, 2'b00);
    tick();
    a_pkt(1'b1, 2'd2, I_ADDU, 32'h808, I_ADDIU, 32'h80C, 2'b00);
    a_flush = 1'b1; a_out_take = 2'd1; rst = 1'b1;
    tick();
    rst = 1'b0; a_flush = 1'b0; a_out_take = 2'd0;
    a_pkt(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    checks++; if (a_out_valid !== 2'b00 || a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid got valid=%b ready=%b want 00/1", a_out_valid, a_in_ready); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_basic();
    test_predecode();
    test_pairing();
    test_flush();
    test_adel();
    test_full_wrap();
    test_single_issue_ds();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
